// File: rtl/rf_deserializer_out.sv
// rf_deserializer_out
// Takes one parallel result vector of ARRAYLEN words per transaction from the
// systolic array and streams it out one word per cycle, lane 0 first.
// A two-slot ping-pong buffer absorbs back-to-back array bursts.
// Occupancy (EMPTY/HALF/FULL) is the state of the buffer.
// Optional build macro: RF_DESERIALIZER_OUT_RELU_EN. When it is defined,
// negative words are clamped to zero on the output side only. The stored
// slots are never modified.

module rf_deserializer_out #(
    parameter int WORDWIDTH = 32,
    parameter int ARRAYLEN  = 25,
    parameter int LANE_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ARRAYLEN*WORDWIDTH-1:0] din,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WORDWIDTH-1:0]          dout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [LANE_W-1:0]             out_lane
);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(ARRAYLEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t                 cnt;
    logic                 wp;
    logic                 rp;
    logic [LANE_W-1:0]    lane;
    logic [WORDWIDTH-1:0] slot [2][ARRAYLEN];

    logic                 accept;
    logic                 pop;
    logic                 retire;
    logic [WORDWIDTH-1:0] sel_word;

`ifdef RF_DESERIALIZER_OUT_RELU_EN
    // Negative two's complement words are clamped to zero.
    function automatic logic [WORDWIDTH-1:0] relu(input logic [WORDWIDTH-1:0] w);
        logic [WORDWIDTH-1:0] r;
        if (w[WORDWIDTH-1]) begin
            r = '0;
        end else begin
            r = w;
        end
        return r;
    endfunction
`endif

    // Handshake qualifiers. These are derived from registered state only.
    // in_ready therefore has no path from out_ready.
    always_comb begin
        in_ready  = (cnt != FULL) && !rst;
        out_valid = (cnt != EMPTY);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
        retire    = pop && (lane == LANE_LAST);
        sel_word  = slot[rp][lane];
    end

    // Output word, lane tag and last flag. dout is forced to zero while no word is valid.
    always_comb begin
        out_lane = lane;
        out_last = out_valid && (lane == LANE_LAST);
        if (out_valid) begin
`ifdef RF_DESERIALIZER_OUT_RELU_EN
            dout = relu(sel_word);
`else
            dout = sel_word;
`endif
        end else begin
            dout = '0;
        end
    end

    // Vector storage: the accepted vector is written into the slot selected by wp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < ARRAYLEN; i++) begin
                    slot[s][i] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < ARRAYLEN; i++) begin
                slot[wp][i] <= din[i*WORDWIDTH +: WORDWIDTH];
            end
        end
    end

    // Pointers, lane counter and occupancy state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            lane <= '0;
            cnt  <= EMPTY;
        end else begin
            if (accept) begin
                wp <= ~wp;
            end
            if (pop) begin
                if (lane == LANE_LAST) begin
                    lane <= '0;
                    rp   <= ~rp;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
            case (cnt)
                EMPTY: begin
                    if (accept) begin
                        cnt <= HALF;
                    end else begin
                        cnt <= EMPTY;
                    end
                end
                HALF: begin
                    case ({accept, retire})
                        2'b10:   cnt <= FULL;
                        2'b01:   cnt <= EMPTY;
                        default: cnt <= HALF;
                    endcase
                end
                FULL: begin
                    if (retire) begin
                        cnt <= HALF;
                    end else begin
                        cnt <= FULL;
                    end
                end
                default: cnt <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_deserializer_out.sv
// Self-checking bench for rf_deserializer_out.
// The reference model is a flat queue of expected output words (word, lane).
// Buffer occupancy is derived from the queue length. Each clock cycle the
// DUT outputs are compared against the head of the queue.
// The bench honours RF_DESERIALIZER_OUT_RELU_EN in its expected values.

module tb_rf_deserializer_out;

    localparam int WW = 32;
    localparam int AL = 25;
    localparam int LW = 5;

    typedef struct {
        logic [WW-1:0] w;
        int            lane;
    } word_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [AL*WW-1:0]    din;
    logic                in_valid;
    logic                in_ready;
    logic [WW-1:0]       dout;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [LW-1:0]       out_lane;

    word_t q[$];
    int total = 0;
    int bad   = 0;

    rf_deserializer_out #(.WORDWIDTH(WW), .ARRAYLEN(AL), .LANE_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_lane  (out_lane)
    );

    always #5 clk = ~clk;

    // Vectors not yet completely streamed out.
    function automatic int outstanding();
        return (q.size() + AL - 1) / AL;
    endfunction

    function automatic logic [WW-1:0] expect_word(input logic [WW-1:0] w);
`ifdef RF_DESERIALIZER_OUT_RELU_EN
        if (w[WW-1]) return 32'd0;
`endif
        return w;
    endfunction

    function automatic logic [AL*WW-1:0] mk_vec(input int base);
        logic [AL*WW-1:0] v;
        for (int i = 0; i < AL; i++) v[i*WW +: WW] = WW'(base + i);
        return v;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic          ev;
        logic [WW-1:0] ed;
        int            el;
        ev = (q.size() != 0);
        ed = ev ? expect_word(q[0].w) : 32'd0;
        el = ev ? q[0].lane : 0;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".dout"}, dout, ed);
        chk({tag, ".out_lane"}, {27'd0, out_lane}, WW'(el));
        chk({tag, ".out_last"}, {31'd0, out_last}, {31'd0, ev && (el == AL - 1)});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, !rst && (outstanding() < 2)});
    endtask

    // One clock cycle: drive the inputs, predict the handshakes, advance the model, then check.
    task automatic step(input string tag, input logic iv, input logic [AL*WW-1:0] d,
                        input logic ordy, output logic acc);
        logic pp;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        acc = iv && (outstanding() < 2);
        pp  = (q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (pp) void'(q.pop_front());
        if (acc) begin
            for (int i = 0; i < AL; i++) begin
                word_t e;
                e.w = d[i*WW +: WW];
                e.lane = i;
                q.push_back(e);
            end
        end
        check_all(tag);
    endtask

    initial begin
        logic             acc;
        logic             v2_taken;
        logic [AL*WW-1:0] v;
        logic [3:0]       pat;

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        #2;
        check_all("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all("post_reset");

        // Single vector, lanes 100..124, no backpressure
        step("t1", 1'b1, mk_vec(100), 1'b1, acc);
        for (int i = 0; i < AL + 2; i++) step("t1", 1'b0, '0, 1'b1, acc);

        // Three vectors offered back to back while the output is stalled
        step("t2", 1'b1, mk_vec(32'h000), 1'b0, acc);
        step("t2", 1'b1, mk_vec(32'h100), 1'b0, acc);
        for (int i = 0; i < 3; i++) step("t2", 1'b1, mk_vec(32'h200), 1'b0, acc);
        v2_taken = 1'b0;
        for (int i = 0; i < 4 * AL; i++) begin
            step("t2", !v2_taken, mk_vec(32'h200), 1'b1, acc);
            if (acc) v2_taken = 1'b1;
        end
        chk("t2.v2_accepted", {31'd0, v2_taken}, 32'd1);

        // Backpressure: out_ready follows the pattern 1,0,0,1
        pat = 4'b1001;
        step("t3", 1'b1, mk_vec(32'h500), 1'b0, acc);
        for (int i = 0; i < 4 * AL; i++) step("t3", 1'b0, '0, pat[i % 4], acc);

        // Accept on the same cycle that lane 24 pops
        step("t4", 1'b1, mk_vec(32'h600), 1'b1, acc);
        for (int i = 0; i < AL - 1; i++) step("t4", 1'b0, '0, 1'b1, acc);
        step("t4", 1'b1, mk_vec(32'h700), 1'b1, acc);
        chk("t4.accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < AL + 1; i++) step("t4", 1'b0, '0, 1'b1, acc);

        // Reset while vector 0 is at lane 10 and vector 1 is buffered
        step("t5", 1'b1, mk_vec(32'h800), 1'b0, acc);
        step("t5", 1'b1, mk_vec(32'h900), 1'b0, acc);
        for (int i = 0; i < 10; i++) step("t5", 1'b0, '0, 1'b1, acc);
        rst = 1'b1; out_ready = 1'b0;
        q.delete();
        #1;
        check_all("t5.in_reset");
        @(posedge clk); #1;
        check_all("t5.in_reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("t5.idle", 1'b0, '0, 1'b1, acc);
        step("t5.fresh", 1'b1, mk_vec(32'hA00), 1'b1, acc);
        for (int i = 0; i < AL + 1; i++) step("t5.fresh", 1'b0, '0, 1'b1, acc);

        // Alternating negative / positive words (clamped only in the ReLU build)
        for (int i = 0; i < AL; i++) v[i*WW +: WW] = (i % 2 == 0) ? 32'hFFFF_FFF6 : 32'd7;
        step("t6", 1'b1, v, 1'b1, acc);
        for (int i = 0; i < AL + 1; i++) step("t6", 1'b0, '0, 1'b1, acc);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < AL; i++) v[i*WW +: WW] = $urandom;
            step("rand", 1'($urandom_range(0, 1)), v, ($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 2 * AL + 2; i++) step("drain", 1'b0, '0, 1'b1, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
